// File: rtl/ita_hwpe_package.sv
`default_nettype none
// ============================================================================
// ita_hwpe_package : ITA job descriptor layout and sequencer state encoding
// Rev 1.0
// ============================================================================
package ita_hwpe_package;

  typedef struct packed {
    logic [31:0] input_ptr;
    logic [31:0] weight_ptr0;
    logic [31:0] weight_ptr1;
    logic [31:0] bias_ptr;
    logic [31:0] output_ptr;
    logic [15:0] tiles;
    logic [3:0]  ctrl_engine;
    logic [4:0]  ctrl_stream;
    logic        irq_en;
  } ita_job_desc_t;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD   = 3'd1,
    SEQ_START  = 3'd2,
    SEQ_WAIT   = 3'd3,
    SEQ_RETIRE = 3'd4,
    SEQ_DRAIN  = 3'd5,
    SEQ_ERROR  = 3'd6
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ita_job_fifo.sv
`default_nettype none
// ============================================================================
// ita_job_fifo : circular descriptor buffer with push/pop/flush and occupancy
// Rev 1.0
// ============================================================================
module ita_job_fifo #(
  parameter type         T_DATA = logic,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  T_DATA                    data_i,
  input  logic                     pop_i,
  output T_DATA                    data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ready_o
);
  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_LVL_W = c_PTR_W + 1;

  T_DATA              r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               w_push;
  logic               w_pop;

  assign ready_o = (r_level != c_LVL_W'(DEPTH));
  assign w_push  = push_i && ready_o;
  assign w_pop   = pop_i && (r_level != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Depth is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + c_LVL_W'(1);
      else if (w_pop && !w_push) r_level <= r_level - c_LVL_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ita_job_sequencer.sv
`default_nettype none
// ============================================================================
// ita_job_sequencer : queues ITA job descriptors and issues them back-to-back
//                     to the HWPE controller, with completion event and watchdog
// Rev 1.0
// ============================================================================
module ita_job_sequencer
  import ita_hwpe_package::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         desc_valid_i,
  output logic                         desc_ready_o,
  input  ita_job_desc_t                desc_i,
  output ita_job_desc_t                job_desc_o,
  output logic                         start_o,
  input  logic                         ctrl_busy_i,
  input  logic                         ctrl_done_i,
  output logic                         evt_o,
  output logic                         busy_o,
  output logic [$clog2(QUEUE_DEPTH):0] level_o,
  output logic [CNT_W-1:0]             jobs_done_o,
  output logic                         error_o
);
  localparam int unsigned c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  seq_state_e         r_state;
  ita_job_desc_t      r_job_desc;
  logic               r_start;
  logic               r_evt;
  logic               r_error;
  logic [CNT_W-1:0]   r_jobs_done;
  logic [c_WD_W-1:0]  r_wdog;

  ita_job_desc_t      w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_wd_expire;

  assign w_push = desc_valid_i && desc_ready_o && !clear_i;
  assign w_pop  = (r_state == SEQ_IDLE) && (level_o != '0) && !ctrl_busy_i
                  && !r_error && !clear_i;

  ita_job_fifo #(
    .T_DATA (ita_job_desc_t),
    .DEPTH  (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (w_push),
    .data_i  (desc_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .level_o (level_o),
    .ready_o (desc_ready_o)
  );

  if (TIMEOUT_CYCLES != 0) begin : g_wdog_on
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);
    assign w_wd_expire = (r_wdog == c_WD_LIMIT);
  end else begin : g_wdog_off
    assign w_wd_expire = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= SEQ_IDLE;
      r_job_desc  <= '0;
      r_start     <= 1'b0;
      r_evt       <= 1'b0;
      r_error     <= 1'b0;
      r_jobs_done <= '0;
      r_wdog      <= '0;
    end else begin
      r_start <= 1'b0;
      r_evt   <= 1'b0;
      if (clear_i) begin
        // An issued job may still be running; wait for the engine to go idle.
        r_error <= 1'b0;
        r_state <= ((r_state == SEQ_START) || (r_state == SEQ_WAIT)) ? SEQ_DRAIN : SEQ_IDLE;
      end else begin
        unique case (r_state)
          SEQ_IDLE: begin
            if (w_pop) begin
              r_job_desc <= w_head;
              r_state    <= SEQ_LOAD;
            end
          end
          SEQ_LOAD: begin
            r_start <= 1'b1;
            r_state <= SEQ_START;
          end
          SEQ_START: begin
            r_wdog  <= '0;
            r_state <= SEQ_WAIT;
          end
          SEQ_WAIT: begin
            if (ctrl_done_i) begin
              r_evt       <= r_job_desc.irq_en;
              r_jobs_done <= r_jobs_done + CNT_W'(1);
              r_state     <= SEQ_RETIRE;
            end else if (w_wd_expire) begin
              r_error <= 1'b1;
              r_state <= SEQ_ERROR;
            end else begin
              r_wdog <= r_wdog + c_WD_W'(1);
            end
          end
          SEQ_RETIRE: r_state <= SEQ_IDLE;
          SEQ_DRAIN: begin
            if (!ctrl_busy_i) r_state <= SEQ_IDLE;
          end
          SEQ_ERROR: r_state <= SEQ_ERROR;
          default:   r_state <= SEQ_IDLE;
        endcase
      end
    end
  end

  assign job_desc_o  = r_job_desc;
  assign start_o     = r_start;
  assign evt_o       = r_evt;
  assign error_o     = r_error;
  assign jobs_done_o = r_jobs_done;
  assign busy_o      = (r_state != SEQ_IDLE) || (level_o != '0);

endmodule
`default_nettype wire

// File: tb/tb_ita_job_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ita_job_sequencer : scoreboard bench for the ITA job sequencer
// Rev 1.0
// ============================================================================
module tb_ita_job_sequencer;
  import ita_hwpe_package::*;

  localparam int unsigned QD = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 16;

  logic            clk          = 1'b0;
  logic            rst_ni       = 1'b0;
  logic            clear_i      = 1'b0;
  logic            desc_valid_i = 1'b0;
  logic            ctrl_busy_i  = 1'b0;
  logic            ctrl_done_i  = 1'b0;
  ita_job_desc_t   desc_i       = '0;
  ita_job_desc_t   job_desc_o;
  logic            desc_ready_o;
  logic            start_o;
  logic            evt_o;
  logic            busy_o;
  logic            error_o;
  logic [$clog2(QD):0] level_o;
  logic [CW-1:0]   jobs_done_o;

  int n_checks  = 0;
  int n_errors  = 0;
  int evt_seen  = 0;
  ita_job_desc_t exp_q[$];
  ita_job_desc_t mon_exp;

  ita_job_sequencer #(
    .QUEUE_DEPTH    (QD),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .desc_i       (desc_i),
    .job_desc_o   (job_desc_o),
    .start_o      (start_o),
    .ctrl_busy_i  (ctrl_busy_i),
    .ctrl_done_i  (ctrl_done_i),
    .evt_o        (evt_o),
    .busy_o       (busy_o),
    .level_o      (level_o),
    .jobs_done_o  (jobs_done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every start pulse must issue the oldest still-expected descriptor.
  always @(negedge clk) begin
    if (evt_o === 1'b1) evt_seen++;
    if (start_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("start_unexpected", 256'(start_o), 256'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("start_desc", 256'(job_desc_o), 256'(mon_exp));
      end
    end
  end

  function automatic ita_job_desc_t make_desc(input logic [31:0] p, input logic irq);
    ita_job_desc_t d;
    d.input_ptr   = p;
    d.weight_ptr0 = p + 32'h1000;
    d.weight_ptr1 = p + 32'h2000;
    d.bias_ptr    = p + 32'h3000;
    d.output_ptr  = p + 32'h4000;
    d.tiles       = p[15:0] ^ 16'h00ff;
    d.ctrl_engine = p[11:8];
    d.ctrl_stream = p[12:8];
    d.irq_en      = irq;
    return d;
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input ita_job_desc_t d, input bit expect_start);
    if (expect_start) exp_q.push_back(d);
    desc_valid_i = 1'b1;
    desc_i       = d;
    tick();
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (start_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("start_seen", 256'(start_o), 256'(1));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 256'(desc_ready_o), 256'(1));
    chk({tag, "_start"}, 256'(start_o), 256'(0));
    chk({tag, "_evt"}, 256'(evt_o), 256'(0));
    chk({tag, "_busy"}, 256'(busy_o), 256'(0));
    chk({tag, "_level"}, 256'(level_o), 256'(0));
    chk({tag, "_jobs"}, 256'(jobs_done_o), 256'(0));
    chk({tag, "_error"}, 256'(error_o), 256'(0));
    chk({tag, "_desc"}, 256'(job_desc_o), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    tick(3);
    chk_reset_state("reset");
    rst_ni = 1'b1;
    tick();

    // Single job: push at t, start at t+3, done at d, evt at d+1, idle at d+2.
    push_one(make_desc(32'h0000_0050, 1'b1), 1'b1);
    chk("t1_level", 256'(level_o), 256'(1));
    chk("t1_no_start_t1", 256'(start_o), 256'(0));
    tick();
    chk("t1_no_start_t2", 256'(start_o), 256'(0));
    tick();
    chk("t1_start_t3", 256'(start_o), 256'(1));
    ctrl_busy_i = 1'b1;
    tick();
    chk("t1_start_one_cycle", 256'(start_o), 256'(0));
    chk("t1_busy_wait", 256'(busy_o), 256'(1));
    tick(10);
    ctrl_done_i = 1'b1;
    tick();
    ctrl_done_i = 1'b0;
    ctrl_busy_i = 1'b0;
    chk("t1_evt", 256'(evt_o), 256'(1));
    chk("t1_jobs", 256'(jobs_done_o), 256'(1));
    tick();
    chk("t1_evt_pulse", 256'(evt_o), 256'(0));
    chk("t1_idle", 256'(busy_o), 256'(0));

    // Five descriptors into a depth-4 queue while the controller is busy.
    ctrl_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push_one(make_desc(32'h100 * (i + 1), 1'(i % 2)), 1'b1);
    chk("t2_full_level", 256'(level_o), 256'(4));
    chk("t2_full_ready", 256'(desc_ready_o), 256'(0));
    desc_valid_i = 1'b1;
    desc_i       = make_desc(32'h500, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_hold_ready", 256'(desc_ready_o), 256'(0));
      chk("t2_hold_level", 256'(level_o), 256'(4));
    end
    exp_q.push_back(make_desc(32'h500, 1'b1));
    ctrl_busy_i = 1'b0;
    tick();
    chk("t2_ready_after_pop", 256'(desc_ready_o), 256'(1));
    chk("t2_level_after_pop", 256'(level_o), 256'(3));
    tick();
    desc_valid_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_start();
      tick(3);
      ctrl_done_i = 1'b1;
      tick();
      ctrl_done_i = 1'b0;
    end
    tick(2);
    chk("t2_jobs", 256'(jobs_done_o), 256'(6));
    chk("t2_evts", 256'(evt_seen), 256'(4));
    chk("t2_idle", 256'(busy_o), 256'(0));

    // Watchdog: last WAIT cycle is start+20, error visible the cycle after.
    push_one(make_desc(32'h600, 1'b1), 1'b1);
    wait_start();
    tick(TO);
    chk("t3_err_before", 256'(error_o), 256'(0));
    tick();
    chk("t3_err_rise", 256'(error_o), 256'(1));
    push_one(make_desc(32'h700, 1'b0), 1'b0);
    chk("t3_push_in_error", 256'(level_o), 256'(1));
    tick(5);
    chk("t3_err_sticky", 256'(error_o), 256'(1));
    chk("t3_fifo_frozen", 256'(level_o), 256'(1));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("t3_clear_err", 256'(error_o), 256'(0));
    chk("t3_clear_level", 256'(level_o), 256'(0));
    chk("t3_jobs_kept", 256'(jobs_done_o), 256'(6));
    chk("t3_idle", 256'(busy_o), 256'(0));

    // Clear during WAIT -> drain; a done while draining is swallowed.
    push_one(make_desc(32'h800, 1'b1), 1'b1);
    wait_start();
    ctrl_busy_i = 1'b1;
    tick(2);
    clear_i      = 1'b1;
    desc_valid_i = 1'b1;
    desc_i       = make_desc(32'h900, 1'b1);
    tick();
    clear_i      = 1'b0;
    desc_valid_i = 1'b0;
    chk("t4_push_dropped", 256'(level_o), 256'(0));
    chk("t4_drain_busy", 256'(busy_o), 256'(1));
    tick(2);
    ctrl_done_i = 1'b1;
    tick();
    ctrl_done_i = 1'b0;
    tick(4);
    chk("t4_no_evt", 256'(evt_seen), 256'(4));
    chk("t4_no_count", 256'(jobs_done_o), 256'(6));
    chk("t4_still_drain", 256'(busy_o), 256'(1));
    ctrl_busy_i = 1'b0;
    tick();
    chk("t4_idle", 256'(busy_o), 256'(0));

    // Spurious done in IDLE, then done on the exact timeout cycle.
    ctrl_done_i = 1'b1;
    tick();
    ctrl_done_i = 1'b0;
    tick();
    chk("t5_spurious_jobs", 256'(jobs_done_o), 256'(6));
    chk("t5_spurious_evt", 256'(evt_seen), 256'(4));
    push_one(make_desc(32'hA00, 1'b1), 1'b1);
    wait_start();
    tick(TO);
    ctrl_done_i = 1'b1;
    tick();
    ctrl_done_i = 1'b0;
    chk("t5_done_wins_err", 256'(error_o), 256'(0));
    chk("t5_done_wins_evt", 256'(evt_o), 256'(1));
    chk("t5_done_wins_jobs", 256'(jobs_done_o), 256'(7));
    tick();
    chk("t5_idle", 256'(busy_o), 256'(0));

    // Reset while in WAIT with three queued descriptors.
    push_one(make_desc(32'hB00, 1'b0), 1'b1);
    wait_start();
    tick(2);
    for (int i = 0; i < 3; i++) push_one(make_desc(32'hC00 + 32'h100 * i, 1'b1), 1'b0);
    chk("t6_level3", 256'(level_o), 256'(3));
    rst_ni = 1'b0;
    tick();
    chk_reset_state("t6_reset");
    rst_ni = 1'b1;
    tick(5);
    chk("t6_stays_idle", 256'(busy_o), 256'(0));
    chk("t6_scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
